// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage behind the instruction buffer.
//   clk, reset (async, active low)
//   entries            : buffer contents, index 0 oldest (only slots 0/1 read)
//   is_really_commited : slot k retires this cycle (slot 1 implies slot 0)
//   is_commited_store  : retiring slot k is a store
//   commited_tags      : tag of slot k, always driven
//   rf_we/rf_waddr/rf_wdata : register-file write ports, one per slot
//   mem_req/mem_addr/mem_wdata/mem_mode, mem_ack : single-outstanding store write-back
//   instret            : retired-instruction counter
package commit_pkg;
   typedef enum logic [2:0] {
      S_NOT_USED       = 3'd0,
      S_NOT_EXECUTED   = 3'd1,
      S_EXECUTING      = 3'd2,
      S_ADDR_GENERATED = 3'd3,
      S_EXECUTED       = 3'd4
   } e_state_t;

   typedef enum logic [1:0] {
      ALU    = 2'd0,
      LOAD   = 2'd1,
      STORE  = 2'd2,
      BRANCH = 2'd3
   } unit_t;

   typedef enum logic [2:0] {
      BYTE   = 3'b000,
      HALF   = 3'b001,
      WORD   = 3'b010,
      BYTE_U = 3'b011,
      HALF_U = 3'b100
   } ldst_mode_t;

   typedef logic [3:0] tag_t;

   typedef struct packed {
      e_state_t   e_state;
      logic [5:0] speculative_tag;
      logic [5:0] specific_speculative_tag;
      unit_t      Unit;
      tag_t       tag;
      logic [4:0] Dest;
      logic [31:0] result;
      logic [31:0] A;
      logic [31:0] Vk;
      ldst_mode_t rwmm;
   } entry_t;
endpackage

module commit_unit
   import commit_pkg::*;
#(
   parameter int unsigned BUF_SIZE  = 16,
   parameter int unsigned INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  entry_t               entries [BUF_SIZE],
   output logic [1:0]           is_really_commited,
   output logic [1:0]           is_commited_store,
   output tag_t                 commited_tags [2],
   output logic [1:0]           rf_we,
   output logic [4:0]           rf_waddr [2],
   output logic [31:0]          rf_wdata [2],
   output logic                 mem_req,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   output ldst_mode_t           mem_mode,
   input  logic                 mem_ack,
   output logic [INSTRET_W-1:0] instret
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } store_state_t;

   store_state_t store_state;
   logic [1:0]   eligible;
   logic [1:0]   is_store;
   logic         unused_upper_slots;

   always_comb begin
      for (int unsigned k = 0; k < 2; k++) begin
         eligible[k] = (entries[k].e_state == S_EXECUTED) &&
                       (entries[k].speculative_tag == '0) &&
                       (entries[k].specific_speculative_tag == '0);
         is_store[k] = (entries[k].Unit == STORE);
      end
   end

   // Slot 1 may retire only behind slot 0, and at most one store per cycle.
   always_comb begin
      is_really_commited    = '0;
      is_really_commited[0] = eligible[0] && (!is_store[0] || store_state == ST_IDLE);
      is_really_commited[1] = is_really_commited[0] && eligible[1] &&
                              (!is_store[1] || (!is_store[0] && store_state == ST_IDLE));
   end

   always_comb begin
      for (int unsigned k = 0; k < 2; k++) begin
         is_commited_store[k] = is_really_commited[k] && is_store[k];
         rf_we[k]             = is_really_commited[k] && !is_store[k] && (entries[k].Dest != '0);
         commited_tags[k]     = entries[k].tag;
         rf_waddr[k]          = entries[k].Dest;
         rf_wdata[k]          = entries[k].result;
      end
   end

   always_comb begin
      unused_upper_slots = 1'b0;
      for (int unsigned i = 2; i < BUF_SIZE; i++) begin
         unused_upper_slots = unused_upper_slots ^ (^entries[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         store_state <= ST_IDLE;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_mode    <= BYTE;
         instret     <= '0;
      end else begin
         instret <= instret + INSTRET_W'(is_really_commited[0]) + INSTRET_W'(is_really_commited[1]);
         case (store_state)
            ST_IDLE: begin
               if (is_commited_store[0]) begin
                  mem_addr    <= entries[0].A;
                  mem_wdata   <= entries[0].Vk;
                  mem_mode    <= entries[0].rwmm;
                  mem_req     <= 1'b1;
                  store_state <= ST_REQ;
               end else if (is_commited_store[1]) begin
                  mem_addr    <= entries[1].A;
                  mem_wdata   <= entries[1].Vk;
                  mem_mode    <= entries[1].rwmm;
                  mem_req     <= 1'b1;
                  store_state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  mem_req     <= 1'b0;
                  store_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed test-plan sequences plus randomized cycles,
// checked against a queue-free behavioural model of in-order retirement.
module tb_commit_unit;
   import commit_pkg::*;

   logic        clk;
   logic        reset;
   entry_t      entries [16];
   logic [1:0]  is_really_commited;
   logic [1:0]  is_commited_store;
   tag_t        commited_tags [2];
   logic [1:0]  rf_we;
   logic [4:0]  rf_waddr [2];
   logic [31:0] rf_wdata [2];
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   ldst_mode_t  mem_mode;
   logic        mem_ack;
   logic [63:0] instret;

   int n_tests;
   int n_fail;

   // model state
   logic        m_pending;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   logic [2:0]  m_mode;
   logic [63:0] m_instret;

   entry_t ent [16];
   logic   ack;

   commit_unit #(.BUF_SIZE(16), .INSTRET_W(64)) dut (
      .clk                (clk),
      .reset              (reset),
      .entries            (entries),
      .is_really_commited (is_really_commited),
      .is_commited_store  (is_commited_store),
      .commited_tags      (commited_tags),
      .rf_we              (rf_we),
      .rf_waddr           (rf_waddr),
      .rf_wdata           (rf_wdata),
      .mem_req            (mem_req),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_mode           (mem_mode),
      .mem_ack            (mem_ack),
      .instret            (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic entry_t empty_entry();
      entry_t e;
      e = '0;
      return e;
   endfunction

   function automatic entry_t mk(input unit_t u, input e_state_t s, input logic [4:0] d,
                                 input logic [31:0] res, input logic [31:0] a,
                                 input logic [31:0] vk, input ldst_mode_t md);
      entry_t e;
      e = '0;
      e.Unit = u; e.e_state = s; e.Dest = d; e.result = res;
      e.A = a; e.Vk = vk; e.rwmm = md; e.tag = tag_t'($urandom_range(0, 15));
      return e;
   endfunction

   function automatic entry_t rand_entry();
      entry_t e;
      e.e_state = ($urandom_range(0, 9) < 6) ? S_EXECUTED : e_state_t'($urandom_range(0, 3));
      e.speculative_tag          = ($urandom_range(0, 4) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
      e.specific_speculative_tag = ($urandom_range(0, 4) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
      e.Unit   = unit_t'($urandom_range(0, 3));
      e.tag    = tag_t'($urandom_range(0, 15));
      e.Dest   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      e.result = $urandom;
      e.A      = $urandom;
      e.Vk     = $urandom;
      e.rwmm   = ldst_mode_t'($urandom_range(0, 4));
      return e;
   endfunction

   function automatic void clear_ent();
      for (int i = 0; i < 16; i++) ent[i] = empty_entry();
   endfunction

   // One clock cycle: apply ent/ack, check outputs against model, advance model.
   task automatic step();
      int     n;
      int     sidx;
      logic   store_taken;
      logic   ok;
      @(negedge clk);
      entries = ent;
      mem_ack = ack;
      #2;
      // Retire the longest oldest-first run of ready entries, at most one store,
      // and no store while a write-back is outstanding.
      n = 0; sidx = -1; store_taken = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ok = (ent[k].e_state == S_EXECUTED) && (ent[k].speculative_tag == 0) &&
              (ent[k].specific_speculative_tag == 0);
         if (ok && ent[k].Unit == STORE) begin
            if (m_pending || store_taken) ok = 1'b0;
            else begin
               store_taken = 1'b1;
               sidx = k;
            end
         end
         if (!ok) break;
         n++;
      end
      for (int k = 0; k < 2; k++) begin
         check($sformatf("commit[%0d]", k), 64'(is_really_commited[k]), 64'(k < n));
         check($sformatf("store[%0d]", k), 64'(is_commited_store[k]), 64'(k < n && ent[k].Unit == STORE));
         check($sformatf("rf_we[%0d]", k), 64'(rf_we[k]),
               64'(k < n && ent[k].Unit != STORE && ent[k].Dest != 0));
         check($sformatf("tag[%0d]", k), 64'(commited_tags[k]), 64'(ent[k].tag));
         check($sformatf("waddr[%0d]", k), 64'(rf_waddr[k]), 64'(ent[k].Dest));
         check($sformatf("wdata[%0d]", k), 64'(rf_wdata[k]), 64'(ent[k].result));
      end
      check("mem_req", 64'(mem_req), 64'(m_pending));
      if (m_pending) begin
         check("mem_addr", 64'(mem_addr), 64'(m_addr));
         check("mem_wdata", 64'(mem_wdata), 64'(m_data));
         check("mem_mode", 64'(mem_mode), 64'(m_mode));
      end
      check("instret", instret, m_instret);
      @(posedge clk);
      m_instret = m_instret + 64'(n);
      if (m_pending) begin
         if (ack) m_pending = 1'b0;
      end else if (sidx >= 0) begin
         m_pending = 1'b1;
         m_addr    = ent[sidx].A;
         m_data    = ent[sidx].Vk;
         m_mode    = ent[sidx].rwmm;
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      m_pending = 1'b0; m_addr = '0; m_data = '0; m_mode = '0; m_instret = '0;
      reset = 1'b0; ack = 1'b0; mem_ack = 1'b0;
      clear_ent();
      entries = ent;
      #3;
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_mem_mode", 64'(mem_mode), 64'd0);
      check("rst_instret", instret, 64'd0);
      check("rst_commit", 64'(is_really_commited), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // ALU in slot 0, slot 1 still executing
      clear_ent();
      ent[0] = mk(ALU, S_EXECUTED, 5'd5, 32'h1234, '0, '0, BYTE);
      ent[1] = mk(ALU, S_EXECUTING, 5'd3, 32'h1, '0, '0, BYTE);
      step();
      // two ALUs, Dest 0 and 7
      ent[0] = mk(ALU, S_EXECUTED, 5'd0, 32'hAAAA, '0, '0, BYTE);
      ent[1] = mk(ALU, S_EXECUTED, 5'd7, 32'hBBBB, '0, '0, BYTE);
      step();
      // single store, ack low 3 cycles then high
      clear_ent();
      ent[0] = mk(STORE, S_EXECUTED, 5'd0, '0, 32'h100, 32'hDEADBEEF, WORD);
      step();
      clear_ent();
      for (int c = 0; c < 3; c++) step();
      ack = 1'b1; step();
      ack = 1'b0; step();
      // back-to-back stores
      ent[0] = mk(STORE, S_EXECUTED, 5'd0, '0, 32'h200, 32'h11111111, HALF);
      ent[1] = mk(STORE, S_EXECUTED, 5'd0, '0, 32'h300, 32'h22222222, BYTE_U);
      step();
      ent[0] = ent[1]; ent[1] = empty_entry();
      step(); step();
      ack = 1'b1; step();
      ack = 1'b0; step();
      step();
      ack = 1'b1; step();
      ack = 1'b0;
      // speculative entry, then tag clears
      clear_ent();
      ent[0] = mk(ALU, S_EXECUTED, 5'd9, 32'h55, '0, '0, BYTE);
      ent[0].speculative_tag = 6'b000010;
      step(); step();
      ent[0].speculative_tag = 6'b0;
      step();
      // load that only generated its address waits
      ent[0] = mk(LOAD, S_ADDR_GENERATED, 5'd4, 32'h9, 32'h40, '0, WORD);
      step();

      // randomized cycles
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 16; i++) ent[i] = rand_entry();
         ack = m_pending && ($urandom_range(0, 2) == 0);
         step();
      end

      // async reset while a store is outstanding
      ack = 1'b0;
      if (m_pending) begin
         ack = 1'b1; clear_ent(); step(); ack = 1'b0;
      end
      clear_ent();
      ent[0] = mk(STORE, S_EXECUTED, 5'd0, '0, 32'h400, 32'h33333333, WORD);
      step();
      clear_ent();
      step();
      @(negedge clk);
      entries = ent;
      #2;
      reset = 1'b0;
      #1;
      check("async_mem_req", 64'(mem_req), 64'd0);
      check("async_instret", instret, 64'd0);
      check("async_commit", 64'(is_really_commited), 64'd0);
      m_pending = 1'b0; m_instret = '0;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage directly downstream of the instruction buffer.
- Each cycle it inspects the two oldest buffer slots, entries[0] and entries[1], and retires up to two executed, non-speculative entries.
- It drives the buffer's commit inputs (is_really_commited, is_commited_store, commited_tags), the architectural register-file write ports, and a single-outstanding store write-back handshake to data memory.
- It keeps a 64-bit retired-instruction counter.

Parameters:
- BUF_SIZE, 16, buffer depth; only slots 0 and 1 are read.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- entries  in  entry_t x BUF_SIZE  current buffer contents; index 0 is the oldest.
- is_really_commited  out  1 x 2  slot k retires this cycle.
- is_commited_store  out  1 x 2  retiring slot k is a STORE.
- commited_tags  out  tag_t x 2  tag of slot k (entries[k].tag).
- rf_we  out  1 x 2  register write enable, one per slot.
- rf_waddr  out  5 x 2  destination register, from entries[k].Dest.
- rf_wdata  out  32 x 2  write data, from entries[k].result.
- mem_req  out  1  store write request valid.
- mem_addr  out  32  store address.
- mem_wdata  out  32  store data.
- mem_mode  out  ldst_mode_t  store width.
- mem_ack  in  1  memory accepts the request in this cycle.
- instret  out  INSTRET_W  count of retired instructions.

Behaviour:
- Slot k is eligible when all three hold:
  - entries[k].e_state == S_EXECUTED;
  - entries[k].speculative_tag == 0;
  - entries[k].specific_speculative_tag == 0.
- Retirement decision is combinational from entries and the current FSM state, with zero latency. The buffer consumes is_really_commited in the same cycle.
- Slot 0 retires when it is eligible AND (it is not a STORE OR store_state == ST_IDLE).
- Slot 1 retires only when all of these hold:
  - slot 0 retires this cycle;
  - slot 1 is eligible;
  - slot 1 is not a STORE, or (slot 0 is not a STORE and store_state == ST_IDLE).
  - This enforces at most one store per cycle.
- Invariant: is_really_commited[1] implies is_really_commited[0].
- is_commited_store[k] = is_really_commited[k] AND Unit == STORE. When the slot does not retire, it is 0.
- commited_tags[k] = entries[k].tag. This output is always driven; it is meaningful only when the slot retires.
- rf_we[k] = is_really_commited[k] AND Unit != STORE AND Dest != 0.
- rf_waddr and rf_wdata pass through combinationally.
- If both slots write the same Dest in one cycle, slot 1 is the younger; the register file gives port 1 priority. This block enables both writes regardless.
- Store FSM has two states, ST_IDLE and ST_REQ.
  - ST_IDLE: when a STORE retires in slot j, the following are captured at the clock edge: mem_addr <= entries[j].A, mem_wdata <= entries[j].Vk, mem_mode <= entries[j].rwmm. The FSM then moves to ST_REQ.
  - ST_REQ: mem_req = 1. Address, data and mode stay stable until mem_ack.
  - On mem_ack the FSM returns to ST_IDLE. The next store may retire in the cycle after the ack, not in the ack cycle. Store-to-store throughput is one per 2 cycles at best.
  - While in ST_REQ, a STORE at slot 0 does not retire. Non-store entries ahead of it retire normally; the stall holds everything behind it because retirement is in order.
- mem_req is 1 only in ST_REQ.
- instret increments by is_really_commited[0] + is_really_commited[1] each cycle, wrapping modulo 2^INSTRET_W.
- Reset (asynchronous, on reset == 0):
  - store_state = ST_IDLE, mem_req = 0, mem_addr = 0, mem_wdata = 0, mem_mode = BYTE (3'b000), instret = 0.
  - An outstanding store is abandoned mid-handshake. mem_req drops immediately without waiting for the clock.
- Combinational outputs follow entries during reset. Because the buffer is also held in reset, entries are 0 (S_NOT_USED), so nothing retires.
- An entry in state S_NOT_USED, S_NOT_EXECUTED, S_EXECUTING or S_ADDR_GENERATED never retires. A load that has only generated its address waits.

Test Plan:
- Slot 0 is ALU, S_EXECUTED, spec tags 0, Dest=5, result=0x1234; slot 1 is S_EXECUTING.
  - Required: is_really_commited={1,0}, rf_we[0]=1, rf_waddr[0]=5, rf_wdata[0]=0x1234, instret goes 0->1.
- Slots 0 and 1 are both executed ALU entries with Dest=0 and Dest=7.
  - Required: both retire, rf_we={0,1}, instret +2.
- Slot 0 is an executed STORE with A=0x100, Vk=0xDEADBEEF, rwmm=WORD; mem_ack held low 3 cycles, then high.
  - Required: is_commited_store[0]=1 in cycle 0.
  - mem_req=1 with addr 0x100 and data 0xDEADBEEF from cycle 1 through the ack cycle, then 0.
- Back-to-back executed STOREs in slots 0 and 1.
  - Required: only slot 0 retires; slot 1 (now at index 0) retires one cycle after mem_ack, not earlier.
- Slot 0 is executed but speculative_tag=6'b000010.
  - Required: no retirement; once the tag clears, it retires in that same cycle.
- reset is pulled low asynchronously mid-cycle while in ST_REQ.
  - Required: mem_req falls to 0 without a clock edge; instret=0; after release no request is reissued.
